// File: rtl/freq_meter.sv
// Period/high-time meter: measures an asynchronous slow signal in clock_in cycles.
// Optional high-time measurement is built only when DUTY_MEASURE_EN is defined.
`timescale 1ns/1ps
module freq_meter #(
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] TIMEOUT     = 28'd100000000,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             signal_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             valid,
  output logic             timeout,
  output logic             measuring
);

  // state   | meaning
  // ARM     | waiting for a first rising edge, cnt held at 0
  // MEASURE | counting cycles between consecutive rising edges
  typedef enum logic {ARM, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [WIDTH-1:0]       cnt;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARM;
      cnt        <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      measuring  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ARM: begin
          cnt <= '0;
          if (rise) begin
            state     <= MEASURE;
            measuring <= 1'b1;
            cnt       <= {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        MEASURE: begin
          // A rise landing on the timeout cycle is still a valid measurement.
          if (rise) begin
            period_out <= cnt;
            valid      <= 1'b1;
            timeout    <= 1'b0;
            cnt        <= {{(WIDTH-1){1'b0}}, 1'b1};
          end else if (cnt == TIMEOUT) begin
            timeout   <= 1'b1;
            state     <= ARM;
            measuring <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= ARM;
          measuring <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

`ifdef DUTY_MEASURE_EN
  logic [WIDTH-1:0] hcnt;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      hcnt     <= '0;
      duty_out <= '0;
    end else if (rise) begin
      // The rise cycle itself is the first high cycle of the new period.
      if (state == MEASURE) duty_out <= hcnt;
      hcnt <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (state == MEASURE && cnt != TIMEOUT && s) begin
      hcnt <= hcnt + 1'b1;
    end
  end
`else
  assign duty_out = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (TIMEOUT=64): scoreboard of expected periods
// derived from the driven waveform, plus directed timeout/reset checks.
`timescale 1ns/1ps
module tb_freq_meter;
  localparam int W = 28;

  logic          clock_in = 1'b0;
  logic          reset_n  = 1'b0;
  logic          signal_in = 1'b0;
  logic [W-1:0]  period_out;
  logic [W-1:0]  duty_out;
  logic          valid;
  logic          timeout;
  logic          measuring;

  freq_meter #(.WIDTH(W), .TIMEOUT(28'd64), .SYNC_STAGES(2)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .signal_in  (signal_in),
    .period_out (period_out),
    .duty_out   (duty_out),
    .valid      (valid),
    .timeout    (timeout),
    .measuring  (measuring)
  );

  always #10 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] per;
    logic [W-1:0] duty;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   have_prev = 0;
  int   prev_hi, prev_lo, rise_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_duty(input int hi);
`ifdef DUTY_MEASURE_EN
    return W'(hi);
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Each driven rise closes the previous period, whose length the bench already knows.
  task automatic note_rise(input int hi, input int lo);
    exp_t e;
    if (have_prev) begin
      e.per  = W'(prev_hi + prev_lo);
      e.duty = exp_duty(prev_hi);
      sb.push_back(e);
    end
    have_prev = 1;
    prev_hi   = hi;
    prev_lo   = lo;
    rise_cyc  = cyc;
  endtask

  task automatic run_period(input int hi, input int lo);
    tick();
    signal_in = 1'b1;
    note_rise(hi, lo);
    repeat (hi - 1) tick();
    tick();
    signal_in = 1'b0;
    repeat (lo - 1) tick();
  endtask

  always @(negedge clock_in) begin
    if (reset_n && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("period", period_out, mon_e.per);
        chk("duty", duty_out, mon_e.duty);
        chk("timeout_on_valid", timeout, 32'd0);
        chk("measuring_on_valid", measuring, 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_period", period_out, 32'd0);
    chk("rst_duty", duty_out, 32'd0);
    chk("rst_valid", valid, 32'd0);
    chk("rst_timeout", timeout, 32'd0);
    chk("rst_measuring", measuring, 32'd0);
    reset_n = 1'b1;
    tick();

    // steady period 10, then 7, then the 2-cycle minimum
    repeat (6) run_period(5, 5);
    repeat (5) run_period(3, 4);
    repeat (8) run_period(1, 1);

    // last rise then hold low: timeout lands 64 cycles after the synchronized rise
    run_period(5, 5);
    tick();
    signal_in = 1'b1;
    note_rise(5, 0);
    repeat (5) tick();
    signal_in = 1'b0;
    while (cyc < rise_cyc + 66) tick();
    chk("pre_timeout", timeout, 32'd0);
    chk("pre_timeout_measuring", measuring, 32'd1);
    tick();
    chk("timeout_set", timeout, 32'd1);
    chk("timeout_measuring", measuring, 32'd0);
    chk("period_hold", period_out, 32'd10);
    chk("duty_hold", duty_out, 32'(exp_duty(5)));
    have_prev = 0;
    repeat (10) tick();
    chk("timeout_sticky_idle", timeout, 32'd1);

    // restart: first edge only re-arms, second produces a measurement
    run_period(10, 10);
    chk("timeout_after_first_edge", timeout, 32'd1);
    chk("no_valid_first_edge", sb.size(), 32'd0);
    run_period(10, 10);

    // period exactly equal to TIMEOUT: rise wins
    repeat (3) run_period(32, 32);
    run_period(5, 5);
    chk("timeout_at_boundary", timeout, 32'd0);
    chk("period_64_seen", measuring, 32'd1);

    // async reset mid-measurement
    chk("sb_empty_pre_reset", sb.size(), 32'd0);
    chk("period_pre_reset", period_out, 32'd64);
    reset_n = 1'b0;
    #1;
    chk("arst_period", period_out, 32'd0);
    chk("arst_duty", duty_out, 32'd0);
    chk("arst_valid", valid, 32'd0);
    chk("arst_timeout", timeout, 32'd0);
    chk("arst_measuring", measuring, 32'd0);
    have_prev = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    repeat (4) run_period(5, 5);

    repeat (5) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
